// File: rtl/pwm_sched_if.sv
// Command/argument stream between a command sequencer and pwm_sched.
// master drives the command and argument words; slave consumes them and reports completion.
interface pwm_sched_if #(
  parameter int CMD_BITS = 8
) ();
  logic [CMD_BITS-1:0] cmd;
  logic                cmd_ready;
  logic [31:0]         arg_data;
  logic                arg_advance;
  logic                cmd_done;

  modport master (output cmd, cmd_ready, arg_data, input arg_advance, cmd_done);
  modport slave  (input cmd, cmd_ready, arg_data, output arg_advance, cmd_done);
endinterface

// File: rtl/pwm_sched.sv
// Multi-channel PWM generator whose duty is reloaded from per-channel time-stamped
// queues, fed by a one-argument-per-clock command stream (CONFIG / SCHEDULE).
module pwm_sched #(
  parameter int NPWM             = 12,
  parameter int PWM_BITS         = 26,
  parameter int QDEPTH           = 4,
  parameter int CMD_BITS         = 8,
  parameter int CMD_CONFIG_PWM   = 2,
  parameter int CMD_SCHEDULE_PWM = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     systime,
  input  logic            shutdown,
  pwm_sched_if.slave      bus,
  output logic [NPWM-1:0] pwm,
  output logic            missed_clock,
  output logic            queue_overflow
);
  localparam int CHW = (NPWM > 1) ? $clog2(NPWM) : 1;
  localparam int QAW = $clog2(QDEPTH);
  localparam logic [31:0] LATE = 32'hC000_0000;

  typedef enum logic [2:0] {
    IDLE, CFG_CYCLE, CFG_ON, CFG_FLAGS, CFG_DUR, SCH_TIME, SCH_ON
  } state_t;

  // A time is due when it equals now or lies within the last quarter of the
  // 32-bit circle behind now, so wrap of systime needs no special case.
  function automatic logic is_due(input logic [31:0] t, input logic [31:0] now);
    logic [31:0] delta;
    delta = t - now;
    return (delta == 32'd0) || (delta >= LATE);
  endfunction

  state_t state_q, state_d;
  logic   cmd_done_q, cmd_done_d, adv_q, adv_d;
  logic   missed_q, missed_d, ovf_q, ovf_d;
  logic   is_cfg, is_sch, cfg_commit, sch_commit, miss_set;
  logic [NPWM-1:0] ovf_vec;

  logic [CHW-1:0]      ch_q, ch_d;
  logic                ch_ok_q, ch_ok_d, a_miss_q, a_miss_d;
  logic [PWM_BITS-1:0] a_cycle_q, a_cycle_d, a_on_q, a_on_d;
  logic [2:0]          a_flags_q, a_flags_d;
  logic [31:0]         a_time_q, a_time_d;

  assign is_cfg = bus.cmd == CMD_BITS'(CMD_CONFIG_PWM);
  assign is_sch = bus.cmd == CMD_BITS'(CMD_SCHEDULE_PWM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_done_q <= 1'b0;
      adv_q      <= 1'b0;
      missed_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_done_q <= cmd_done_d;
      adv_q      <= adv_d;
      missed_q   <= missed_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.cmd_ready) begin
                   if (is_cfg)      state_d = CFG_CYCLE;
                   else if (is_sch) state_d = SCH_TIME;
                 end
      CFG_CYCLE: state_d = CFG_ON;
      CFG_ON:    state_d = CFG_FLAGS;
      CFG_FLAGS: state_d = CFG_DUR;
      SCH_TIME:  state_d = SCH_ON;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_done_d = 1'b0;
    cfg_commit = 1'b0;
    sch_commit = 1'b0;
    miss_set   = 1'b0;
    case (state_q)
      IDLE:     cmd_done_d = bus.cmd_ready && !is_cfg && !is_sch;
      CFG_DUR:  begin cmd_done_d = 1'b1; cfg_commit = ch_ok_q; end
      SCH_TIME: miss_set = ch_ok_q && is_due(bus.arg_data, systime);
      SCH_ON:   begin cmd_done_d = 1'b1; sch_commit = ch_ok_q && !a_miss_q; end
      default:  ;
    endcase
  end

  assign adv_d    = 1'b1;
  assign missed_d = missed_q | miss_set;
  assign ovf_d    = ovf_q | (|ovf_vec);

  assign bus.cmd_done    = cmd_done_q;
  assign bus.arg_advance = adv_q;
  assign missed_clock    = missed_q;
  assign queue_overflow  = ovf_q;

  // Argument capture: out-of-range channels are remembered so the command drains harmlessly.
  always_comb begin
    ch_d      = ch_q;
    ch_ok_d   = ch_ok_q;
    a_cycle_d = a_cycle_q;
    a_on_d    = a_on_q;
    a_flags_d = a_flags_q;
    a_time_d  = a_time_q;
    a_miss_d  = a_miss_q;
    case (state_q)
      IDLE:      begin
                   ch_d    = bus.arg_data[CHW-1:0];
                   ch_ok_d = bus.arg_data < 32'(NPWM);
                 end
      CFG_CYCLE: a_cycle_d = bus.arg_data[PWM_BITS-1:0];
      CFG_ON:    a_on_d    = bus.arg_data[PWM_BITS-1:0];
      CFG_FLAGS: a_flags_d = bus.arg_data[2:0];
      SCH_TIME:  begin a_time_d = bus.arg_data; a_miss_d = miss_set; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    ch_q      <= ch_d;
    ch_ok_q   <= ch_ok_d;
    a_cycle_q <= a_cycle_d;
    a_on_q    <= a_on_d;
    a_flags_q <= a_flags_d;
    a_time_q  <= a_time_d;
    a_miss_q  <= a_miss_d;
  end

  for (genvar g = 0; g < NPWM; g++) begin : g_ch
    logic [PWM_BITS-1:0] cycle_q, cycle_d, on_q, on_d, cnt_q, cnt_d, pend_q, pend_d;
    logic [2:0]          flags_q, flags_d;
    logic [31:0]         maxdur_q, maxdur_d, dur_q, dur_d;
    logic                pend_vld_q, pend_vld_d, pwm_q, pwm_d;
    logic [31:0]         qtime_q [QDEPTH];
    logic [31:0]         qtime_d [QDEPTH];
    logic [PWM_BITS-1:0] qon_q [QDEPTH];
    logic [PWM_BITS-1:0] qon_d [QDEPTH];
    logic [QAW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [QAW:0]        qcnt_q, qcnt_d;
    logic                sel, push_ok, pop, wrap, load, epv, ovf;
    logic [PWM_BITS-1:0] load_val, epend;

    assign sel        = ch_q == CHW'(g);
    assign pwm[g]     = pwm_q;
    assign ovf_vec[g] = ovf;

    always_comb begin
      cycle_d    = cycle_q;
      on_d       = on_q;
      flags_d    = flags_q;
      maxdur_d   = maxdur_q;
      dur_d      = dur_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      qtime_d    = qtime_q;
      qon_d      = qon_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      ovf        = 1'b0;
      push_ok    = 1'b0;
      load       = 1'b0;
      load_val   = qon_q[rd_q];

      wrap  = (cycle_q != '0) && (cnt_q >= cycle_q - PWM_BITS'(1));
      cnt_d = (cycle_q == '0 || wrap) ? '0 : cnt_q + PWM_BITS'(1);
      pwm_d = (cycle_q == '0) ? flags_q[0] : ((cnt_q < on_q) ^ flags_q[1]);

      // Queue: occupancy before this cycle's pop decides whether a push fits.
      pop = (qcnt_q != '0) && is_due(qtime_q[rd_q], systime);
      if (sch_commit && sel) begin
        if (qcnt_q == (QAW+1)'(QDEPTH)) begin
          ovf = 1'b1;
        end else begin
          push_ok        = 1'b1;
          qtime_d[wr_q]  = a_time_q;
          qon_d[wr_q]    = bus.arg_data[PWM_BITS-1:0];
          wr_d           = wr_q + QAW'(1);
        end
      end
      if (pop) rd_d = rd_q + QAW'(1);
      qcnt_d = qcnt_q + (QAW+1)'(push_ok) - (QAW+1)'(pop);

      // Sync-update: the newest popped value waits for the wrap so a period is never split.
      epv   = pend_vld_q || (pop && flags_q[2]);
      epend = (pop && flags_q[2]) ? qon_q[rd_q] : pend_q;
      if (pop && !flags_q[2]) begin
        load = 1'b1;
      end else if (epv && wrap) begin
        load     = 1'b1;
        load_val = epend;
      end
      pend_d     = epend;
      pend_vld_d = epv && !wrap;

      if (load) begin
        on_d  = load_val;
        dur_d = maxdur_q;
      end else if (dur_q != '0) begin
        dur_d = dur_q - 32'd1;
        if (dur_q <= 32'd2) on_d = flags_q[0] ? '1 : '0;
      end

      if (cfg_commit && sel) begin
        cycle_d    = a_cycle_q;
        on_d       = a_on_q;
        flags_d    = a_flags_q;
        maxdur_d   = bus.arg_data;
        dur_d      = '0;
        cnt_d      = '0;
        pend_vld_d = 1'b0;
        rd_d       = '0;
        wr_d       = '0;
        qcnt_d     = '0;
      end

      if (shutdown) begin
        on_d       = flags_d[0] ? '1 : '0;
        pend_vld_d = 1'b0;
        rd_d       = '0;
        wr_d       = '0;
        qcnt_d     = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cycle_q    <= '0;
        on_q       <= '0;
        cnt_q      <= '0;
        pend_q     <= '0;
        flags_q    <= '0;
        maxdur_q   <= '0;
        dur_q      <= '0;
        pend_vld_q <= 1'b0;
        pwm_q      <= 1'b0;
        qtime_q    <= '{default: '0};
        qon_q      <= '{default: '0};
        rd_q       <= '0;
        wr_q       <= '0;
        qcnt_q     <= '0;
      end else begin
        cycle_q    <= cycle_d;
        on_q       <= on_d;
        cnt_q      <= cnt_d;
        pend_q     <= pend_d;
        flags_q    <= flags_d;
        maxdur_q   <= maxdur_d;
        dur_q      <= dur_d;
        pend_vld_q <= pend_vld_d;
        pwm_q      <= pwm_d;
        qtime_q    <= qtime_d;
        qon_q      <= qon_d;
        rd_q       <= rd_d;
        wr_q       <= wr_d;
        qcnt_q     <= qcnt_d;
      end
    end
  end
endmodule

// File: tb/tb_pwm_sched.sv
// Directed bench for pwm_sched: command timing, duty, queued/timed loads,
// sync update, duration expiry, shutdown flush and reset behaviour.
module tb_pwm_sched;
  localparam logic [7:0] CFG = 8'd2;
  localparam logic [7:0] SCH = 8'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        shutdown = 1'b0;
  logic [31:0] systime = 32'hFFFF_FFC0;
  logic [11:0] pwm;
  logic        missed_clock, queue_overflow;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_t;

  pwm_sched_if #(.CMD_BITS(8)) bus ();

  pwm_sched dut (
    .clk(clk), .rst(rst), .systime(systime), .shutdown(shutdown), .bus(bus),
    .pwm(pwm), .missed_clock(missed_clock), .queue_overflow(queue_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: DUT samples the current systime at the edge, then time advances.
  task automatic step();
    @(posedge clk);
    #1;
    systime = systime + 32'd1;
  endtask

  task automatic wait_until(input logic [31:0] t);
    for (int k = 0; k < 2000 && systime != t; k++) step();
    chk("wait_time", systime, t);
  endtask

  task automatic send(input string tag, input logic [7:0] c, input int n,
                      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [31:0] a3, input logic [31:0] a4);
    logic [31:0] a [5];
    logic [31:0] mask;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3; a[4] = a4;
    mask = '0;
    bus.cmd = c;
    bus.cmd_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.arg_data = a[k];
      last_t = systime;
      step();
      bus.cmd_ready = 1'b0;
      if (bus.cmd_done) mask[k] = 1'b1;
    end
    chk(tag, mask, 32'd1 << (n - 1));
  endtask

  task automatic count_hi(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      step();
      hi += int'(pwm[ch]);
    end
  endtask

  initial begin
    int hi, hi2, h6, h7, h8;
    logic [31:0] t0, sc;

    bus.cmd = '0; bus.cmd_ready = 1'b0; bus.arg_data = '0;
    step(); step();
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_done", 32'(bus.cmd_done), 32'd0);
    chk("rst_adv", 32'(bus.arg_advance), 32'd0);
    chk("rst_flags", {30'd0, missed_clock, queue_overflow}, 32'd0);
    rst = 1'b0;
    step();
    chk("adv_on", 32'(bus.arg_advance), 32'd1);

    // Basic duty: 3 of every 10, done pulse on the 5th cycle only.
    send("cfg0_done", CFG, 5, 0, 10, 3, 0, 0);
    step();
    chk("cfg0_pulse_end", 32'(bus.cmd_done), 32'd0);
    count_hi(0, 20, hi);
    chk("ch0_duty", 32'(hi), 32'd6);

    // Queue of 4 with timed loads; the 5th push overflows. Times cross the 32-bit wrap.
    send("cfg1_done", CFG, 5, 1, 1, 0, 0, 0);
    t0 = systime;
    send("sch1a", SCH, 3, 1, t0 + 20, 5, 0, 0);
    send("sch1b", SCH, 3, 1, t0 + 40, 0, 0, 0);
    send("sch1c", SCH, 3, 1, t0 + 60, 5, 0, 0);
    send("sch1d", SCH, 3, 1, t0 + 80, 0, 0, 0);
    chk("ovf_before", 32'(queue_overflow), 32'd0);
    send("sch1e", SCH, 3, 1, t0 + 100, 5, 0, 0);
    chk("ovf_after", 32'(queue_overflow), 32'd1);
    for (int j = 0; j < 4; j++) begin
      wait_until(t0 + 32'(20 * (j + 1)));
      step();
      chk("load_old", 32'(pwm[1]), (j % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("load_new", 32'(pwm[1]), (j % 2 == 0) ? 32'd1 : 32'd0);
    end
    wait_until(t0 + 100);
    step(); step(); step();
    chk("fifth_dropped", 32'(pwm[1]), 32'd0);

    // Past time: flagged and discarded.
    chk("miss_before", 32'(missed_clock), 32'd0);
    t0 = systime;
    send("sch_miss", SCH, 3, 1, t0 + 1 - 5, 5, 0, 0);
    chk("miss_after", 32'(missed_clock), 32'd1);
    count_hi(1, 10, hi);
    chk("miss_no_load", 32'(hi), 32'd0);

    // Sync update: pop at counter 40 must wait for the wrap.
    send("cfg4_done", CFG, 5, 4, 100, 10, 4, 0);
    sc = last_t;
    send("sch4", SCH, 3, 4, sc + 41, 60, 0, 0);
    hi = 0; hi2 = 0;
    for (int k = 4; k <= 200; k++) begin
      step();
      if (k <= 100) hi += int'(pwm[4]);
      else hi2 += int'(pwm[4]);
    end
    chk("sync_old_period", 32'(hi), 32'd7);
    chk("sync_new_period", 32'(hi2), 32'd60);

    // Duration expiry with default level 1.
    send("cfg5_done", CFG, 5, 5, 10, 3, 1, 50);
    t0 = systime;
    send("sch5", SCH, 3, 5, t0 + 10, 0, 0, 0);
    wait_until(t0 + 10);
    step();
    count_hi(5, 49, hi);
    chk("dur_inactive", 32'(hi), 32'd0);
    count_hi(5, 11, hi);
    chk("dur_expired", 32'(hi), 32'd11);

    // Disabled channel, invert, on >= cycle.
    send("cfg6_done", CFG, 5, 6, 0, 5, 3, 0);
    send("cfg7_done", CFG, 5, 7, 4, 1, 2, 0);
    send("cfg8_done", CFG, 5, 8, 5, 9, 0, 0);
    h6 = 0; h7 = 0; h8 = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      h6 += int'(pwm[6]); h7 += int'(pwm[7]); h8 += int'(pwm[8]);
    end
    chk("disabled_dflt", 32'(h6), 32'd8);
    chk("invert_duty", 32'(h7), 32'd6);
    chk("on_ge_cycle", 32'(h8), 32'd8);

    // Out-of-range channel and unknown command still complete.
    send("cfg_badch", CFG, 5, 16, 0, 0, 0, 0);
    count_hi(0, 20, hi);
    chk("badch_no_effect", 32'(hi), 32'd6);
    send("unknown_done", 8'd7, 1, 0, 0, 0, 0, 0);
    step();
    chk("unknown_pulse_end", 32'(bus.cmd_done), 32'd0);

    // Shutdown flushes queued entries and forces default levels.
    send("cfg2_done", CFG, 5, 2, 1, 0, 0, 0);
    send("cfg3_done", CFG, 5, 3, 1, 0, 1, 0);
    t0 = systime;
    send("sch2a", SCH, 3, 2, t0 + 40, 5, 0, 0);
    send("sch2b", SCH, 3, 2, t0 + 50, 5, 0, 0);
    send("sch2c", SCH, 3, 2, t0 + 60, 5, 0, 0);
    chk("sd_pre3", 32'(pwm[3]), 32'd0);
    shutdown = 1'b1;
    step();
    shutdown = 1'b0;
    step();
    chk("sd_dflt3", 32'(pwm[3]), 32'd1);
    chk("sd_dflt2", 32'(pwm[2]), 32'd0);
    wait_until(t0 + 65);
    step();
    chk("sd_flushed", 32'(pwm[2]), 32'd0);
    count_hi(0, 10, hi);
    chk("sd_ch0", 32'(hi), 32'd0);

    // Reset in the middle of a command.
    chk("sticky_held", {30'd0, missed_clock, queue_overflow}, 32'd3);
    bus.cmd = CFG; bus.cmd_ready = 1'b1; bus.arg_data = 0;
    step();
    bus.cmd_ready = 1'b0; bus.arg_data = 10;
    step();
    rst = 1'b1;
    #2;
    chk("arst_pwm", 32'(pwm), 32'd0);
    chk("arst_flags", {30'd0, missed_clock, queue_overflow}, 32'd0);
    chk("arst_adv", 32'(bus.arg_advance), 32'd0);
    step();
    rst = 1'b0;
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      hi += int'(bus.cmd_done);
    end
    chk("abort_no_done", 32'(hi), 32'd0);
    chk("adv_after_rst", 32'(bus.arg_advance), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pwm_sched.md
PWM_SCHED -- requirements
Module: pwm_sched

Interface
REQ-001 Parameter NPWM, default 12, number of PWM channels.
REQ-002 Parameter PWM_BITS, default 26, width of cycle/on tick values.
REQ-003 Parameter QDEPTH, default 4 (power of two, >=2), per-channel schedule queue depth.
REQ-004 Parameter CMD_BITS / CMD_CONFIG_PWM / CMD_SCHEDULE_PWM, defaults 8 / 2 / 3, command width and codes.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 systime  input  32  free-running system time, one tick per clk.
REQ-009 arg_data  input  32  current command argument word.
REQ-010 arg_advance  output  1  argument consume strobe; one argument consumed per clock.
REQ-011 cmd  input  CMD_BITS  command code, valid with cmd_ready.
REQ-012 cmd_ready  input  1  command pending; arg_data holds first argument (channel).
REQ-013 cmd_done  output  1  single-cycle pulse, command finished.
REQ-014 pwm  output  NPWM  registered channel outputs.
REQ-015 shutdown  input  1  forces all channels to default level while high.
REQ-016 missed_clock  output  1  sticky: schedule time already passed.
REQ-017 queue_overflow  output  1  sticky: schedule pushed into full queue.

Function
REQ-018 Argument order: CONFIG = channel, cycle_ticks, on_ticks, flags, max_duration; SCHEDULE = channel, time, on_ticks; flags bit0 default level, bit1 invert, bit2 sync-update.
REQ-019 Command FSM states IDLE, CFG_CYCLE, CFG_ON, CFG_FLAGS, CFG_DUR, SCH_TIME, SCH_ON; IDLE leaves only when cmd_ready=1; cmd_done pulses the cycle after the last argument; FSM returns to IDLE.
REQ-020 Unknown cmd in IDLE: cmd_done pulses next cycle, no state change.
REQ-021 Channel value >= NPWM: all arguments consumed, no channel state altered, cmd_done still pulses.
REQ-022 Each channel counter counts 0..cycle_ticks-1 then wraps to 0; cycle_ticks=0 disables the channel: counter held 0, output = default level.
REQ-023 pwm[i] (registered, one-cycle latency) = (counter < on_ticks) XOR invert; on_ticks >= cycle_ticks gives constant active level.
REQ-024 CONFIG completion: loads cycle_ticks, on_ticks, flags, max_duration; clears channel counter, duration and queue.
REQ-025 SCHEDULE: if (time - systime) mod 2^32 is 0 or >= 0xC0000000 at SCH_TIME, set missed_clock and discard entry; else push {time,on_ticks} to channel queue.
REQ-026 Push into full queue (QDEPTH entries): entry discarded, queue_overflow set, queue unchanged.
REQ-027 Head entry pops when (head_time - systime) is 0 or >= 0xC0000000; at most one pop per channel per cycle.
REQ-028 Popped value loads on_ticks immediately if sync-update=0, else held pending and loaded on the cycle the counter wraps to 0; a newer pop overwrites an unapplied pending value.
REQ-029 Each load sets duration to max_duration; nonzero duration decrements per cycle; on reaching 1, on_ticks forced to all-ones if default=1 else 0; max_duration=0 disables the check.
REQ-030 Same-cycle load and duration expiry: load wins.
REQ-031 shutdown=1: every channel on_ticks forced to default level each cycle, queues flushed, pending sync values dropped; shutdown overrides load and config of on_ticks.
REQ-032 Push and pop on same channel in same cycle: both performed; full-queue test uses pre-pop occupancy.
REQ-033 All time comparisons are modulo 2^32; systime wrap from 0xFFFFFFFF to 0 requires no special handling.

Reset
REQ-034 rst=1: pwm=0, cmd_done=0, arg_advance=0, missed_clock=0, queue_overflow=0, FSM IDLE, all channel registers zero, queues empty.
REQ-035 After rst deasserts, arg_advance=1 permanently; sticky flags cleared only by rst.
REQ-036 rst mid-command aborts the command; no cmd_done is issued for it.

Verification
REQ-037 CONFIG ch0 cycle=10 on=3 flags=0 dur=0 -> pwm[0] high 3 of every 10 cycles, cmd_done one pulse 5 cycles after cmd_ready.
REQ-038 SCHEDULE ch1 times T+20,T+40,T+60,T+80,T+100 with QDEPTH=4 -> first four load on_ticks at exact times, fifth sets queue_overflow.
REQ-039 SCHEDULE with time=systime-5 -> missed_clock=1, queue empty, on_ticks unchanged.
REQ-040 sync=1, cycle=100, update pops at counter 40 -> duty changes only after counter wraps to 0, no partial-period glitch.
REQ-041 dur=50, default=1, schedule on=0 -> output inactive for 49 cycles, then constant active level.
REQ-042 shutdown pulse with 3 queued entries -> outputs at default level, queues empty, later systime matches load nothing.
